// File: rtl/dense_layer_engine_if.sv
// dense_layer_engine_if: stream, ROM and status signals of the dense layer engine.
// slave = engine side, master = environment side (source, ROMs, sink).
interface dense_layer_engine_if #(
  parameter int DATA_W  = 16,
  parameter int N_OUT   = 120,
  parameter int ADDR_W  = 10,
  parameter int BADDR_W = 7
);
  logic                      ena;
  logic                      valid_in;
  logic                      frame_start_in;
  logic                      frame_end_in;
  logic [DATA_W-1:0]         dense_input;
  logic                      ready_in;
  logic [ADDR_W-1:0]         w_addr;
  logic [N_OUT*DATA_W-1:0]   w_data;
  logic [BADDR_W-1:0]        b_addr;
  logic [DATA_W-1:0]         b_data;
  logic                      valid_out;
  logic                      frame_start_out;
  logic                      frame_end_out;
  logic [DATA_W-1:0]         dense_out;
  logic                      frame_err;

  modport slave (
    input  ena, valid_in, frame_start_in, frame_end_in, dense_input, w_data, b_data,
    output ready_in, w_addr, b_addr, valid_out, frame_start_out, frame_end_out,
           dense_out, frame_err
  );

  modport master (
    output ena, valid_in, frame_start_in, frame_end_in, dense_input, w_data, b_data,
    input  ready_in, w_addr, b_addr, valid_out, frame_start_out, frame_end_out,
           dense_out, frame_err
  );
endinterface

// File: rtl/dense_layer_engine.sv
// dense_layer_engine: serial-in / serial-out fully-connected layer.
// One input frame of N_IN samples drives N_OUT parallel MACs against a wide
// weight ROM; each neuron then gets its bias, a FRAC_W rescale and saturation,
// and the results leave as a serial frame of N_OUT samples.
// Optional: define DENSE_RELU_EN to clamp negative results to zero at the
// output register (timing unchanged).
module dense_layer_engine #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int N_IN    = 400,
  parameter int N_OUT   = 120,
  parameter int ACC_W   = 40,
  parameter int ADDR_W  = 10,
  parameter int BADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  dense_layer_engine_if.slave bus
);

  localparam int J_W = BADDR_W + 1;
  localparam int Y_W = ACC_W + 1;
  localparam logic [ADDR_W-1:0]       K_LAST = ADDR_W'(N_IN - 1);
  localparam logic [J_W-1:0]          J_LAST = J_W'(N_OUT + 1);
  localparam logic signed [Y_W-1:0]   Y_MAX  = Y_W'(2**(DATA_W-1) - 1);
  localparam logic signed [Y_W-1:0]   Y_MIN  = Y_W'(-(2**(DATA_W-1)));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_SERIAL} state_t;

  state_t                     r_state, w_state_nxt;
  logic [ADDR_W-1:0]          r_k, w_k_nxt, w_k_cur;
  logic [J_W-1:0]             r_j, w_j_nxt;
  logic                       r_err, w_err_set;
  logic                       w_ready, w_accept, w_take;

  logic [ADDR_W-1:0]          r_w_hold, w_w_live;
  logic [BADDR_W-1:0]         r_b_hold, w_b_live;

  logic signed [DATA_W-1:0]   r_x;
  logic                       r_mac_v, r_first;
  logic signed [ACC_W-1:0]    r_acc [N_OUT];
  logic signed [2*DATA_W-1:0] w_prod [N_OUT];

  logic                       w_cmp_v;
  logic [J_W-1:0]             w_cmp_idx;
  logic signed [ACC_W-1:0]    w_acc_sel, w_shift;
  logic signed [Y_W-1:0]      w_y;
  logic signed [DATA_W-1:0]   w_sat, w_res;

  logic                       r_valid_out, r_fs_out, r_fe_out;
  logic [DATA_W-1:0]          r_dense_out;

  // Handshake, frame-length checking and next-state decode
  always_comb begin
    w_ready     = ~rst & ((r_state == S_IDLE) | (r_state == S_ACCUM));
    w_accept    = bus.valid_in & w_ready & bus.ena;
    w_take      = w_accept & ((r_state == S_ACCUM) | bus.frame_start_in);
    w_k_cur     = bus.frame_start_in ? '0 : r_k;
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_err_set   = 1'b0;
    w_j_nxt     = '0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_take) begin
          if (bus.frame_end_in && (w_k_cur == K_LAST)) begin
            w_state_nxt = S_FLUSH;
          end else if (bus.frame_end_in || (w_k_cur == K_LAST)) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_k_nxt     = w_k_cur + ADDR_W'(1);
            w_state_nxt = S_ACCUM;
          end
        end
      end
      S_FLUSH:  w_state_nxt = S_SERIAL;
      S_SERIAL: begin
        // SERIAL spans the bias read and output register stages, so the
        // state only drops back to IDLE once the last result is on the bus.
        if (r_j == J_LAST) w_state_nxt = S_IDLE;
        else               w_j_nxt     = r_j + J_W'(1);
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, sample index, neuron index and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_j     <= '0;
      r_err   <= 1'b0;
    end else if (bus.ena) begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_j     <= w_j_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // ROM addresses: while ena is low the last enabled address is replayed so
  // the 1-cycle ROM data stays aligned with the frozen pipeline.
  always_comb begin
    if (r_state == S_IDLE) w_w_live = '0;
    else if (w_take)       w_w_live = w_k_cur;
    else                   w_w_live = r_w_hold;
    w_b_live = r_j[BADDR_W-1:0];
  end

  // Remember the addresses presented in the last enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_hold <= '0;
      r_b_hold <= '0;
    end else if (bus.ena) begin
      r_w_hold <= w_w_live;
      r_b_hold <= w_b_live;
    end
  end

  // Per-neuron signed products of the delayed sample and its weight
  always_comb begin
    for (int unsigned n = 0; n < N_OUT; n++) begin
      w_prod[n] = r_x * $signed(bus.w_data[n*DATA_W +: DATA_W]);
    end
  end

  // Sample delay stage and the N_OUT accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_mac_v <= 1'b0;
      r_first <= 1'b0;
      for (int unsigned n = 0; n < N_OUT; n++) r_acc[n] <= '0;
    end else if (bus.ena) begin
      r_mac_v <= w_take;
      if (w_take) begin
        r_x     <= $signed(bus.dense_input);
        r_first <= (w_k_cur == '0);
      end
      if (r_mac_v) begin
        for (int unsigned n = 0; n < N_OUT; n++) begin
          r_acc[n] <= (r_first ? '0 : r_acc[n]) +
                      {{(ACC_W-2*DATA_W){w_prod[n][2*DATA_W-1]}}, w_prod[n]};
        end
      end
    end
  end

  // Output datapath: select accumulator, rescale, add bias, saturate
  always_comb begin
    w_cmp_v   = (r_state == S_SERIAL) && (r_j != '0) && (r_j <= J_W'(N_OUT));
    w_cmp_idx = r_j - J_W'(1);
    w_acc_sel = '0;
    for (int unsigned n = 0; n < N_OUT; n++) begin
      if (w_cmp_idx == J_W'(n)) w_acc_sel = r_acc[n];
    end
    w_shift = w_acc_sel >>> FRAC_W;
    w_y     = {w_shift[ACC_W-1], w_shift} +
              {{(Y_W-DATA_W){bus.b_data[DATA_W-1]}}, bus.b_data};
    if (w_y > Y_MAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_y < Y_MIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                  w_sat = w_y[DATA_W-1:0];
`ifdef DENSE_RELU_EN
    w_res = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    w_res = w_sat;
`endif
  end

  // Output register and frame markers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_out <= 1'b0;
      r_fs_out    <= 1'b0;
      r_fe_out    <= 1'b0;
      r_dense_out <= '0;
    end else if (bus.ena) begin
      r_valid_out <= w_cmp_v;
      r_fs_out    <= w_cmp_v && (r_j == J_W'(1));
      r_fe_out    <= w_cmp_v && (r_j == J_W'(N_OUT));
      if (w_cmp_v) r_dense_out <= w_res;
    end
  end

  // Pulses are qualified by ena so a frozen cycle never repeats an output
  assign bus.ready_in        = w_ready;
  assign bus.w_addr          = bus.ena ? w_w_live : r_w_hold;
  assign bus.b_addr          = bus.ena ? w_b_live : r_b_hold;
  assign bus.valid_out       = r_valid_out & bus.ena;
  assign bus.frame_start_out = r_fs_out & bus.ena;
  assign bus.frame_end_out   = r_fe_out & bus.ena;
  assign bus.dense_out       = r_dense_out;
  assign bus.frame_err       = r_err;

endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine: randomized self-checking bench for dense_layer_engine
// with synchronous weight/bias ROM models and an arithmetic reference model.
module tb_dense_layer_engine;
  localparam int DATA_W = 16, FRAC_W = 8, N_IN = 4, N_OUT = 3;
  localparam int ACC_W = 40, ADDR_W = 2, BADDR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena_rand = 1'b0;
  int   pe_cnt = 0;
  int   n_chk = 0, n_pass = 0;

  logic signed [15:0] xs   [N_IN];
  logic signed [15:0] wrom [N_IN][N_OUT];
  logic signed [15:0] brom [4];

  logic [15:0] got_d[$];
  logic        got_fs[$], got_fe[$];
  int          got_pe[$];

  dense_layer_engine_if #(.DATA_W(DATA_W), .N_OUT(N_OUT), .ADDR_W(ADDR_W),
                          .BADDR_W(BADDR_W)) bus ();

  dense_layer_engine #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_IN(N_IN), .N_OUT(N_OUT),
                       .ACC_W(ACC_W), .ADDR_W(ADDR_W), .BADDR_W(BADDR_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); pe_cnt++; end

  // Synchronous ROMs, 1-cycle read latency
  always @(posedge clk) begin
    for (int j = 0; j < N_OUT; j++) bus.w_data[j*DATA_W +: DATA_W] <= wrom[bus.w_addr][j];
    bus.b_data <= brom[bus.b_addr];
  end

  initial begin
    bus.ena = 1'b1;
    forever begin
      @(negedge clk);
      bus.ena = ena_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Output sink, sampled 1 time unit before each rising edge
  initial forever begin
    @(negedge clk); #4;
    if (bus.valid_out) begin
      chk("valid_only_with_ena", bus.ena, 1);
      got_d.push_back(bus.dense_out);
      got_fs.push_back(bus.frame_start_out);
      got_fe.push_back(bus.frame_end_out);
      got_pe.push_back(pe_cnt);
    end
  end

  function automatic logic [15:0] ref_out(input int j);
    longint acc = 0;
    longint y;
    for (int k = 0; k < N_IN; k++) acc += longint'(xs[k]) * longint'(wrom[k][j]);
    y = (acc >>> FRAC_W) + longint'(brom[j]);
    if (y > 32767) y = 32767;
    else if (y < -32768) y = -32768;
`ifdef DENSE_RELU_EN
    if (y < 0) y = 0;
`endif
    return 16'(y);
  endfunction

  function automatic logic [15:0] rnd12();
    int v = int'($urandom_range(0, 4095)) - 2048;
    return 16'(v);
  endfunction

  task automatic set_const(input logic [15:0] x, input logic [15:0] w, input logic [15:0] b);
    for (int k = 0; k < N_IN; k++) begin
      xs[k] = x;
      for (int j = 0; j < N_OUT; j++) wrom[k][j] = w;
    end
    for (int j = 0; j < 4; j++) brom[j] = b;
  endtask

  task automatic set_rand();
    for (int k = 0; k < N_IN; k++) begin
      xs[k] = rnd12();
      for (int j = 0; j < N_OUT; j++) wrom[k][j] = rnd12();
    end
    for (int j = 0; j < 4; j++) brom[j] = rnd12();
  endtask

  task automatic clear_q();
    got_d.delete(); got_fs.delete(); got_fe.delete(); got_pe.delete();
  endtask

  // Called at a falling edge; returns at a falling edge after the sample is taken
  task automatic put(input logic [15:0] d, input logic s, input logic e, output int pe);
    int tries = 0;
    pe = -1;
    bus.valid_in = 1'b1; bus.dense_input = d;
    bus.frame_start_in = s; bus.frame_end_in = e;
    forever begin
      #4;
      if (bus.valid_in && bus.ready_in && bus.ena) begin
        pe = pe_cnt + 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
      tries++;
      if (tries > 200) begin chk("accept_timeout", tries, 0); break; end
    end
    bus.valid_in = 1'b0; bus.frame_start_in = 1'b0; bus.frame_end_in = 1'b0;
  endtask

  task automatic send_frame(input int n, input int end_at, input int max_gap, output int end_pe);
    int pe;
    end_pe = -1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        bus.dense_input = 16'($urandom);
        @(negedge clk);
      end
      put(xs[i], i == 0, i == end_at, pe);
      if (i == end_at) end_pe = pe;
    end
  endtask

  task automatic wait_outputs(input string tag, input int n);
    int t = 0;
    while (got_d.size() < n && t < 300) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
    chk({tag, "_out_count"}, got_d.size(), n);
  endtask

  task automatic compare_frame(input string tag, input int epe, input bit timing);
    for (int j = 0; j < N_OUT; j++) begin
      if (j < got_d.size()) begin
        chk({tag, "_dense_out"}, got_d[j], ref_out(j));
        chk({tag, "_frame_start_out"}, got_fs[j], j == 0);
        chk({tag, "_frame_end_out"}, got_fe[j], j == N_OUT - 1);
        if (timing) chk({tag, "_latency"}, got_pe[j] - epe, 3 + j);
      end
    end
  endtask

  initial begin
    int epe, pe, t, seen;
    bus.valid_in = 1'b0; bus.frame_start_in = 1'b0; bus.frame_end_in = 1'b0;
    bus.dense_input = '0;
    set_const(16'h0100, 16'h0080, 16'h0000);

    // Reset state
    repeat (3) @(negedge clk);
    #4;
    chk("rst_ready_in", bus.ready_in, 0);
    chk("rst_valid_out", bus.valid_out, 0);
    chk("rst_dense_out", bus.dense_out, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    @(negedge clk); rst = 1'b0;
    #4 chk("idle_ready_in", bus.ready_in, 1);
    @(negedge clk);

    // T1: 1.0 x 0.5 x 4 -> 2.0; stray sample without start is ignored first
    put(16'h1234, 1'b0, 1'b0, pe);
    clear_q();
    send_frame(N_IN, N_IN - 1, 0, epe);
    t = 0; pe = -1;
    while (t < 40) begin
      #4;
      if (bus.ready_in) begin pe = pe_cnt; @(negedge clk); break; end
      @(negedge clk); t++;
    end
    chk("t1_ready_return", pe - epe, 6);
    wait_outputs("t1", N_OUT);
    compare_frame("t1", epe, 1'b1);
    if (got_d.size() > 0) chk("t1_value", got_d[0], 16'h0200);
    chk("t1_frame_err", bus.frame_err, 0);

    // T2: positive then negative saturation
    set_const(16'h7F00, 16'h7F00, 16'h0000);
    clear_q(); send_frame(N_IN, N_IN - 1, 0, epe);
    wait_outputs("t2p", N_OUT); compare_frame("t2p", epe, 1'b1);
    if (got_d.size() > 0) chk("t2p_value", got_d[0], 16'h7FFF);
    set_const(16'h7F00, 16'h8100, 16'h0000);
    clear_q(); send_frame(N_IN, N_IN - 1, 0, epe);
    wait_outputs("t2n", N_OUT); compare_frame("t2n", epe, 1'b1);

    // Random operands and biases
    for (int r = 0; r < 3; r++) begin
      set_rand();
      clear_q(); send_frame(N_IN, N_IN - 1, 1, epe);
      wait_outputs("rand", N_OUT); compare_frame("rand", epe, 1'b1);
    end

    // T3: short frame flags error, produces nothing; next frame is fine
    set_rand();
    clear_q(); send_frame(3, 2, 0, epe);
    repeat (12) @(negedge clk);
    chk("t3_frame_err", bus.frame_err, 1);
    chk("t3_no_output", got_d.size(), 0);
    clear_q(); send_frame(N_IN, N_IN - 1, 0, epe);
    wait_outputs("t3_good", N_OUT); compare_frame("t3_good", epe, 1'b1);

    // T4: valid_in (with frame_start_in) held high through SERIAL
    set_const(16'h0100, 16'h0080, 16'h0000);
    clear_q(); send_frame(N_IN, N_IN - 1, 0, epe);
    bus.valid_in = 1'b1; bus.frame_start_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.dense_input = 16'($urandom);
      #4;
      chk("t4_ready_in_low", bus.ready_in, 0);
      if (bus.frame_end_out) break;
      @(negedge clk);
    end
    bus.valid_in = 1'b0; bus.frame_start_in = 1'b0;
    @(negedge clk);
    wait_outputs("t4_hold", N_OUT); compare_frame("t4_hold", epe, 1'b1);
    clear_q(); send_frame(N_IN, N_IN - 1, 3, epe);
    wait_outputs("t4_gap", N_OUT); compare_frame("t4_gap", epe, 1'b1);

    // T5: random clock enable across a whole frame
    clear_q(); ena_rand = 1'b1;
    send_frame(N_IN, N_IN - 1, 1, epe);
    wait_outputs("t5", N_OUT);
    ena_rand = 1'b0;
    compare_frame("t5", epe, 1'b0);

    // T6: reset at the second serial output
    clear_q(); send_frame(N_IN, N_IN - 1, 0, epe);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      #4;
      if (bus.valid_out) seen++;
      if (seen == 2) break;
      @(negedge clk);
    end
    chk("t6_second_output_seen", seen, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid_out", bus.valid_out, 0);
    chk("t6_rst_dense_out", bus.dense_out, 0);
    chk("t6_rst_frame_end_out", bus.frame_end_out, 0);
    chk("t6_rst_frame_err", bus.frame_err, 0);
    chk("t6_rst_ready_in", bus.ready_in, 0);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_no_partial_output", got_d.size(), 2);
    #4 chk("t6_idle_ready_in", bus.ready_in, 1);
    @(negedge clk);
    set_rand();
    clear_q(); send_frame(N_IN, N_IN - 1, 1, epe);
    wait_outputs("t6_good", N_OUT); compare_frame("t6_good", epe, 1'b1);
    chk("t6_frame_err", bus.frame_err, 0);

    // Over-long frame: last index accepted without frame_end_in
    clear_q(); send_frame(N_IN, -1, 0, epe);
    repeat (12) @(negedge clk);
    chk("long_frame_err", bus.frame_err, 1);
    chk("long_no_output", got_d.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
